// File: rtl/pipe_stage_elastic_pkg.sv
// Shared widths and constants for the elastic pipeline stage and its pointer counters.
package pipe_stage_elastic_pkg;

    localparam int PIPE_DATA_LEN = 64;
    localparam int PIPE_INSN_LEN = 32;
    localparam int PIPE_FLAG_LEN = 1;

    // Bubble injected at IF/ID when the stage is empty or flushed (addi x0,x0,0).
    localparam logic [PIPE_INSN_LEN-1:0] PIPE_NOP = 32'h0000_0013;

    // A pointer needs at least one bit even when there is a single entry.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_stage_ptr.sv
// Wrap-at-DEPTH pointer with synchronous clear; clear wins over increment.
module pipe_stage_ptr
    import pipe_stage_elastic_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [PTR_W-1:0] ptr
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    // Explicit compare so non-power-of-two depths wrap at DEPTH-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// DEPTH-entry elastic pipeline register with valid/ready on both sides, plus
// legacy Stall/Flush controls and a bubble value when empty.
module pipe_stage_elastic
    import pipe_stage_elastic_pkg::*;
#(
    parameter int               WIDTH     = PIPE_DATA_LEN,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RST_VALUE = {WIDTH{1'b0}},
    parameter int               CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Stall,
    input  logic             Flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] Count,
    output logic [CNT_W-1:0] MaxCount
);

    localparam int               PTR_W   = ptr_width(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high. in_ready depends only on registered state and Stall, never on
    // out_ready, so chained stages cannot form a combinational ready loop.
    logic             enq;
    logic             deq;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count_next;
    logic [WIDTH-1:0] mem [DEPTH];

    assign in_ready  = !Stall && (Count < DEPTH_C);
    assign out_valid = (Count != '0);
    assign out_data  = out_valid ? mem[head] : RST_VALUE;

    assign enq = in_valid && in_ready && !Flush;
    assign deq = out_valid && out_ready && !Stall && !Flush;

    pipe_stage_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_head_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (deq),
        .clr   (Flush),
        .ptr   (head)
    );

    pipe_stage_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_tail_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (enq),
        .clr   (Flush),
        .ptr   (tail)
    );

    always_comb begin
        count_next = Count;
        if (Flush) begin
            count_next = '0;
        end else begin
            case ({enq, deq})
                2'b10:   count_next = Count + CNT_W'(1);
                2'b01:   count_next = Count - CNT_W'(1);
                default: count_next = Count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Count    <= '0;
            MaxCount <= '0;
        end else begin
            Count <= count_next;
            if (count_next > MaxCount) begin
                MaxCount <= count_next;
            end
        end
    end

    // Payload storage is left unreset; out_data masks it with RST_VALUE while empty.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[tail] <= in_data;
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: DEPTH=2 and DEPTH=3 instances checked every cycle
// against a queue model, plus hand-computed directed expectations.
module tb_pipe_stage_elastic;

    localparam logic [63:0] BUBBLE = 64'h13;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        stall, flush, in_valid, out_ready;
    logic [63:0] in_data;
    logic        in_ready, out_valid;
    logic [63:0] out_data;
    logic [1:0]  count, max_count;

    logic        in_valid_3, out_ready_3;
    logic [63:0] in_data_3;
    logic        in_ready_3, out_valid_3;
    logic [63:0] out_data_3;
    logic [1:0]  count_3, max_count_3;

    int total = 0;
    int bad = 0;

    logic [63:0] exp_q[$];
    logic [63:0] exp_q3[$];
    int          exp_max = 0;
    int          exp_max3 = 0;

    always #5 clk = ~clk;

    pipe_stage_elastic #(.WIDTH(64), .DEPTH(2), .RST_VALUE(64'h13)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Stall     (stall),
        .Flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .Count     (count),
        .MaxCount  (max_count)
    );

    pipe_stage_elastic #(.WIDTH(64), .DEPTH(3), .RST_VALUE(64'h13)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .Stall     (1'b0),
        .Flush     (1'b0),
        .in_valid  (in_valid_3),
        .in_ready  (in_ready_3),
        .in_data   (in_data_3),
        .out_valid (out_valid_3),
        .out_ready (out_ready_3),
        .out_data  (out_data_3),
        .Count     (count_3),
        .MaxCount  (max_count_3)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue model: an item is taken when there is room and no stall; the head
    // leaves when present, requested and not stalled; flush empties everything.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_q3.delete();
            exp_max = 0;
            exp_max3 = 0;
        end else begin
            if (flush) begin
                exp_q.delete();
            end else begin
                bit take, give;
                take = in_valid && !stall && (exp_q.size() < 2);
                give = (exp_q.size() != 0) && out_ready && !stall;
                if (give) void'(exp_q.pop_front());
                if (take) exp_q.push_back(in_data);
            end
            if (exp_q.size() > exp_max) exp_max = exp_q.size();
            begin
                bit take3, give3;
                take3 = in_valid_3 && (exp_q3.size() < 3);
                give3 = (exp_q3.size() != 0) && out_ready_3;
                if (give3) void'(exp_q3.pop_front());
                if (take3) exp_q3.push_back(in_data_3);
            end
            if (exp_q3.size() > exp_max3) exp_max3 = exp_q3.size();
        end
    end

    always @(negedge clk) begin
        chk("d2_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        chk("d2_data",  out_data, (exp_q.size() != 0) ? exp_q[0] : BUBBLE);
        chk("d2_count", 64'(count), 64'(exp_q.size()));
        chk("d2_max",   64'(max_count), 64'(exp_max));
        chk("d2_ready", 64'(in_ready), 64'(!stall && (exp_q.size() < 2)));
        chk("d3_valid", 64'(out_valid_3), 64'(exp_q3.size() != 0));
        chk("d3_data",  out_data_3, (exp_q3.size() != 0) ? exp_q3[0] : BUBBLE);
        chk("d3_count", 64'(count_3), 64'(exp_q3.size()));
        chk("d3_max",   64'(max_count_3), 64'(exp_max3));
        chk("d3_ready", 64'(in_ready_3), 64'(exp_q3.size() < 3));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set(input bit v, input logic [63:0] d, input bit r, input bit s, input bit f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        stall     = s;
        flush     = f;
    endtask

    task automatic set3(input bit v, input logic [63:0] d, input bit r);
        in_valid_3  = v;
        in_data_3   = d;
        out_ready_3 = r;
    endtask

    initial begin
        set(1'b1, 64'hdead, 1'b0, 1'b0, 1'b0);
        set3(1'b0, 64'h0, 1'b0);

        // Reset held with in_valid high
        #2;
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_data",  out_data, 64'h13);
        chk("rst_count", 64'(count), 64'h0);
        chk("rst_max",   64'(max_count), 64'h0);
        mid();
        set(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", 64'(in_ready), 64'h1);
        tick();

        // Streaming
        set(1'b1, 64'hA, 1'b1, 1'b0, 1'b0); mid();
        chk("st_count0", 64'(count), 64'h0); tick();
        set(1'b1, 64'hB, 1'b1, 1'b0, 1'b0); mid();
        chk("st_a", out_data, 64'hA); chk("st_cnt_a", 64'(count), 64'h1);
        chk("st_rdy_a", 64'(in_ready), 64'h1); tick();
        set(1'b1, 64'hC, 1'b1, 1'b0, 1'b0); mid();
        chk("st_b", out_data, 64'hB); chk("st_cnt_b", 64'(count), 64'h1); tick();
        set(1'b0, 64'h0, 1'b1, 1'b0, 1'b0); mid();
        chk("st_c", out_data, 64'hC); chk("st_cnt_c", 64'(count), 64'h1); tick();
        mid();
        chk("st_empty", out_data, 64'h13); chk("st_max", 64'(max_count), 64'h1); tick();

        // Backpressure
        set(1'b1, 64'h1, 1'b0, 1'b0, 1'b0); mid(); tick();
        set(1'b1, 64'h2, 1'b0, 1'b0, 1'b0); mid();
        chk("bp_cnt1", 64'(count), 64'h1); tick();
        set(1'b1, 64'h3, 1'b0, 1'b0, 1'b0); mid();
        chk("bp_full_cnt", 64'(count), 64'h2); chk("bp_full_rdy", 64'(in_ready), 64'h0);
        chk("bp_max", 64'(max_count), 64'h2); chk("bp_head", out_data, 64'h1); tick();
        mid();
        chk("bp_hold_cnt", 64'(count), 64'h2); tick();
        set(1'b0, 64'h0, 1'b1, 1'b0, 1'b0); mid();
        chk("bp_d1", out_data, 64'h1); tick();
        mid();
        chk("bp_d2", out_data, 64'h2); chk("bp_d2_cnt", 64'(count), 64'h1); tick();
        mid();
        chk("bp_drained", out_data, 64'h13); chk("bp_drained_v", 64'(out_valid), 64'h0); tick();

        // Stall holds everything
        set(1'b1, 64'h55, 1'b0, 1'b0, 1'b0); mid(); tick();
        set(1'b1, 64'h66, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            mid();
            chk("stall_data", out_data, 64'h55); chk("stall_cnt", 64'(count), 64'h1);
            chk("stall_rdy", 64'(in_ready), 64'h0);
            tick();
        end
        set(1'b0, 64'h0, 1'b1, 1'b0, 1'b0); mid();
        chk("stall_rel", out_data, 64'h55); chk("stall_rel_v", 64'(out_valid), 64'h1); tick();
        mid();
        chk("stall_deq", 64'(count), 64'h0); tick();

        // Flush beats Stall, enq and deq
        set(1'b1, 64'h21, 1'b0, 1'b0, 1'b0); tick();
        set(1'b1, 64'h22, 1'b0, 1'b0, 1'b0); tick();
        set(1'b1, 64'h77, 1'b1, 1'b1, 1'b1); mid();
        chk("fl_pre_cnt", 64'(count), 64'h2); tick();
        set(1'b0, 64'h0, 1'b1, 1'b0, 1'b0); mid();
        chk("fl_cnt", 64'(count), 64'h0); chk("fl_valid", 64'(out_valid), 64'h0);
        chk("fl_data", out_data, 64'h13); chk("fl_max", 64'(max_count), 64'h2);
        tick(); tick(); tick();

        // Asynchronous reset in the middle of traffic
        set(1'b1, 64'h31, 1'b0, 1'b0, 1'b0); tick();
        set(1'b1, 64'h32, 1'b0, 1'b0, 1'b0); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_cnt", 64'(count), 64'h0); chk("ar_valid", 64'(out_valid), 64'h0);
        chk("ar_data", out_data, 64'h13); chk("ar_max", 64'(max_count), 64'h0);
        set(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        mid();
        #1 rst_n = 1'b1;
        tick();

        // DEPTH=3: mixed rates, data changes every cycle, pointers wrap several times
        for (int i = 0; i < 18; i++) begin
            set3((i < 4) ? 1'b1 : (i % 3 != 0), 64'h100 + 64'(i),
                 (i >= 3) ? ((i % 2 == 1) || (i > 10)) : 1'b0);
            mid();
            if (i == 3) begin
                chk("d3_full_cnt", 64'(count_3), 64'h3);
                chk("d3_full_rdy", 64'(in_ready_3), 64'h0);
                chk("d3_full_head", out_data_3, 64'h100);
            end
            if (i == 4) begin
                chk("d3_after_cnt", 64'(count_3), 64'h2);
                chk("d3_after_head", out_data_3, 64'h101);
            end
            tick();
        end
        set3(1'b0, 64'h0, 1'b1);
        repeat (6) tick();
        mid();
        chk("d3_drained", 64'(count_3), 64'h0);
        chk("d3_max_lit", 64'(max_count_3), 64'h3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
